// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB constants: default sizes and FU index assignment on the req/ack vectors.
// Used by cdb_arbiter (CDB_RR_EN selects round-robin) and the FU wrappers.
package cdb_arbiter_pkg;

    localparam int unsigned NUM_FU_DEF = 4;
    localparam int unsigned TAG_W_DEF  = 4;
    localparam int unsigned DATA_W_DEF = 32;

    // Bit position of each functional unit on req/ack/req_tag/req_data
    typedef enum logic [1:0] {
        FU_ADD = 2'd0,
        FU_MUL = 2'd1,
        FU_DIV = 2'd2,
        FU_LS  = 2'd3
    } fu_id_e;

    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Combinational rotating-priority one-hot picker: first requester at or after ptr wins.
// With ptr tied to zero it is a plain lowest-index picker.
module rr_pick
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_FU = NUM_FU_DEF,
    parameter int unsigned PTR_W  = ptr_width(NUM_FU_DEF)
) (
    input  logic [NUM_FU-1:0] req,
    input  logic [PTR_W-1:0]  ptr,
    output logic [NUM_FU-1:0] grant
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < NUM_FU; k++) begin
            // (ptr + k) mod NUM_FU; ptr is always < NUM_FU so one subtraction suffices
            sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_FU)) begin
                sum = sum - (PTR_W+1)'(NUM_FU);
            end
            idx = sum[PTR_W-1:0];
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: one combinational ack per cycle, registered broadcast next cycle.
// CDB_RR_EN defined: round-robin pointer; undefined: fixed lowest-index priority.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_FU = NUM_FU_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned TAG_W  = TAG_W_DEF
) (
    input  logic                     clk,
    input  logic                     nRST,
    input  logic [NUM_FU-1:0]        req,
    input  logic [NUM_FU*TAG_W-1:0]  req_tag,
    input  logic [NUM_FU*DATA_W-1:0] req_data,
    input  logic                     stall,
    output logic [NUM_FU-1:0]        ack,
    output logic                     cdb_valid,
    output logic [TAG_W-1:0]         cdb_tag,
    output logic [DATA_W-1:0]        cdb_data
);

    localparam int unsigned PTR_W = ptr_width(NUM_FU);

    logic [NUM_FU-1:0] grant;
    logic [PTR_W-1:0]  ptr;
    logic [TAG_W-1:0]  tag_arr  [NUM_FU];
    logic [DATA_W-1:0] data_arr [NUM_FU];
    logic [TAG_W-1:0]  win_tag;
    logic [DATA_W-1:0] win_data;

    logic              cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]  cdb_tag_q,   cdb_tag_d;
    logic [DATA_W-1:0] cdb_data_q,  cdb_data_d;

    for (genvar g = 0; g < NUM_FU; g++) begin : g_unpack
        assign tag_arr[g]  = req_tag[g*TAG_W +: TAG_W];
        assign data_arr[g] = req_data[g*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NUM_FU (NUM_FU),
        .PTR_W  (PTR_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .grant (grant)
    );

    // Reset gates ack combinationally so a pending grant is dropped immediately
    assign ack = (nRST && !stall) ? grant : '0;

    always_comb begin
        win_tag  = '0;
        win_data = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (ack[i]) begin
                win_tag  = tag_arr[i];
                win_data = data_arr[i];
            end
        end
    end

`ifdef CDB_RR_EN
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] win_idx;

    always_comb begin
        win_idx = '0;
        for (int unsigned i = 0; i < NUM_FU; i++) begin
            if (ack[i]) begin
                win_idx = PTR_W'(i);
            end
        end
        ptr_d = ptr_q;
        if (|ack) begin
            ptr_d = (win_idx == PTR_W'(NUM_FU-1)) ? '0 : win_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    always_comb begin
        cdb_valid_d = |ack;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        if (|ack) begin
            cdb_tag_d  = win_tag;
            cdb_data_d = win_data;
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
        end else begin
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_data_q  <= cdb_data_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed steps plus randomized FU traffic
// against a queue-free behavioural model of the grant/broadcast rules.
module tb_cdb_arbiter;

    localparam int NUM_FU = 4;
    localparam int TAG_W  = 4;
    localparam int DATA_W = 32;

    logic                     clk = 1'b0;
    logic                     nRST;
    logic [NUM_FU-1:0]        req;
    logic [NUM_FU*TAG_W-1:0]  req_tag;
    logic [NUM_FU*DATA_W-1:0] req_data;
    logic                     stall;
    logic [NUM_FU-1:0]        ack;
    logic                     cdb_valid;
    logic [TAG_W-1:0]         cdb_tag;
    logic [DATA_W-1:0]        cdb_data;

    cdb_arbiter #(
        .NUM_FU (NUM_FU),
        .DATA_W (DATA_W),
        .TAG_W  (TAG_W)
    ) dut (
        .clk       (clk),
        .nRST      (nRST),
        .req       (req),
        .req_tag   (req_tag),
        .req_data  (req_data),
        .stall     (stall),
        .ack       (ack),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .cdb_data  (cdb_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int                m_ptr = 0;
    logic              m_valid;
    logic [TAG_W-1:0]  m_tag;
    logic [DATA_W-1:0] m_data;
    logic [TAG_W-1:0]  fu_tag  [NUM_FU];
    logic [DATA_W-1:0] fu_data [NUM_FU];
    int                last_w;
    logic [NUM_FU-1:0] last_ack;
    int                bc42;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NUM_FU-1:0] r);
`ifdef CDB_RR_EN
        for (int k = 0; k < NUM_FU; k++)
            if (r[(m_ptr + k) % NUM_FU]) return (m_ptr + k) % NUM_FU;
`else
        for (int k = 0; k < NUM_FU; k++)
            if (r[k]) return k;
`endif
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < NUM_FU; i++) begin
            req_tag[i*TAG_W +: TAG_W]    = fu_tag[i];
            req_data[i*DATA_W +: DATA_W] = fu_data[i];
        end
    endtask

    // One clock: check ack against model, take the edge, check the broadcast
    task automatic cycle();
        int w;
        #1;
        w = (stall || !nRST) ? -1 : pick(req);
        last_ack = ack;
        chk("ack", {60'd0, ack}, (w < 0) ? 64'd0 : (64'd1 << w));
        @(posedge clk);
        if (w >= 0) begin
            m_valid = 1'b1;
            m_tag   = fu_tag[w];
            m_data  = fu_data[w];
            m_ptr   = (w + 1) % NUM_FU;
        end else begin
            m_valid = 1'b0;
        end
        #1;
        chk("cdb_valid", {63'd0, cdb_valid}, {63'd0, m_valid});
        chk("cdb_tag", {60'd0, cdb_tag}, {60'd0, m_tag});
        chk("cdb_data", {32'd0, cdb_data}, {32'd0, m_data});
        if (cdb_valid && cdb_data == 32'd42) bc42++;
        last_w = w;
    endtask

    logic [NUM_FU-1:0] exp_seq [4];

    initial begin
        nRST   = 1'b0;
        req    = '0;
        stall  = 1'b0;
        m_valid = 1'b0;
        m_tag  = '0;
        m_data = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            fu_tag[i]  = TAG_W'(i + 1);
            fu_data[i] = 32'h100 + 32'(i);
        end
        drive();
        #12;
        chk("rst_ack", {60'd0, ack}, 64'd0);
        chk("rst_valid", {63'd0, cdb_valid}, 64'd0);
        chk("rst_tag", {60'd0, cdb_tag}, 64'd0);
        chk("rst_data", {32'd0, cdb_data}, 64'd0);
        nRST = 1'b1;

        // Contention: req=1011 held, pointer starts at 0
`ifdef CDB_RR_EN
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0010; exp_seq[2] = 4'b1000; exp_seq[3] = 4'b0001;
`else
        exp_seq[0] = 4'b0001; exp_seq[1] = 4'b0001; exp_seq[2] = 4'b0001; exp_seq[3] = 4'b0001;
`endif
        req = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            cycle();
            chk("cont_seq", {60'd0, last_ack}, {60'd0, exp_seq[k]});
        end
        req = '0;
        cycle();

        // Single request
        fu_tag[1]  = 4'd5;
        fu_data[1] = 32'h0000_00C8;
        drive();
        req = 4'b0010;
        cycle();
        chk("single_ack", {60'd0, last_ack}, 64'b0010);
        chk("single_tag", {60'd0, cdb_tag}, 64'd5);
        chk("single_data", {32'd0, cdb_data}, 64'hC8);
        req = '0;
        cycle();
        chk("single_drop", {63'd0, cdb_valid}, 64'd0);

        // Stall holds off a waiting requester for three cycles
        fu_tag[2]  = 4'd6;
        fu_data[2] = 32'hDEAD_0006;
        drive();
        req   = 4'b0100;
        stall = 1'b1;
        for (int k = 0; k < 3; k++) cycle();
        stall = 1'b0;
        cycle();
        chk("stall_release", {60'd0, last_ack}, 64'b0100);
        req = '0;
        cycle();

        // Multiplier-style FU1: 7*6 broadcast exactly once
        bc42       = 0;
        fu_tag[1]  = 4'd3;
        fu_data[1] = 32'd7 * 32'd6;
        drive();
        req = 4'b0010;
        cycle();
        req = '0;
        for (int k = 0; k < 3; k++) cycle();
        chk("mul_once", 64'(bc42), 64'd1);

        // Reset mid-operation
        for (int i = 0; i < NUM_FU; i++) fu_tag[i] = TAG_W'(8 + i);
        drive();
        req = 4'b1111;
        cycle();
        chk("pre_rst_valid", {63'd0, cdb_valid}, 64'd1);
        nRST = 1'b0;
        #1;
        chk("mid_rst_ack", {60'd0, ack}, 64'd0);
        chk("mid_rst_valid", {63'd0, cdb_valid}, 64'd0);
        chk("mid_rst_tag", {60'd0, cdb_tag}, 64'd0);
        chk("mid_rst_data", {32'd0, cdb_data}, 64'd0);
        m_ptr   = 0;
        m_valid = 1'b0;
        m_tag   = '0;
        m_data  = '0;
        @(posedge clk);
        #1;
        nRST = 1'b1;
        cycle();
        chk("post_rst_first", {60'd0, last_ack}, 64'b0001);

        // Randomized FU traffic obeying the hold-until-ack contract
        for (int n = 0; n < 400; n++) begin
            if (last_w >= 0) req[last_w] = 1'b0;
            for (int i = 0; i < NUM_FU; i++) begin
                if (!req[i] && $urandom_range(1, 0) == 1) begin
                    req[i]     = 1'b1;
                    fu_tag[i]  = TAG_W'($urandom);
                    fu_data[i] = $urandom;
                end
            end
            stall = ($urandom_range(4, 0) == 0);
            drive();
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
